uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, 16, clk cycles per UART bit; 16 clk cycles of 74 time units give a 1184-unit bit time.
REQ-002 Parameter DATA_BITS, 8, data bits per frame.
REQ-003 clk  in  1  sole clock; all logic on rising edge; one clock.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in  in  1  serial RX line, idle high, asynchronous to clk.
REQ-006 clkinVGA  in  1  reserved input; never used as a clock; no functional effect.
REQ-007 c_valid  in  1  config write request.
REQ-008 c_addr  in  4  config register address.
REQ-009 c_data  in  8  config write data.
REQ-010 c_ready  out  1  config write can be accepted.
REQ-011 error  out  2  [0] framing error, [1] parity error.
REQ-012 valid_error  out  1  one-cycle pulse qualifying error.
REQ-013 out  out  8  received byte.
REQ-014 valid_out  out  1  one-cycle pulse qualifying out.

Function
REQ-015 in SHALL pass through a 2-flop synchronizer before any use; all sampling refers to the synchronized value.
REQ-016 Frames are LSB first: start bit (0), DATA_BITS data bits, optional parity bit, then 1 or 2 stop bits (1).
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2; a single counter (0..OVERSAMPLE-1) and a bit index (0..DATA_BITS-1) time the states.
REQ-018 IDLE -> START on synchronized in = 0; START SHALL re-check in at count OVERSAMPLE/2-1 (mid-bit).
REQ-019 In START, if in = 1 at mid-bit, the FSM SHALL return to IDLE (glitch) with no output and no error.
REQ-020 In START, if in = 0 at mid-bit, the FSM SHALL go to DATA, and every later bit SHALL be sampled exactly OVERSAMPLE cycles after the previous sample.
REQ-021 DATA shifts each sample into bit index 0..7 (LSB first); after index 7 the FSM SHALL go to PARITY if parity is enabled, else to STOP1.
REQ-022 PARITY samples one bit and compares it with the computed parity of the 8 data bits.
REQ-023 STOP1 samples the stop bit; if stop_two = 1 the FSM SHALL go to STOP2, which samples a second stop bit.
REQ-024 The last stop sample SHALL return the FSM to IDLE in the same cycle, so a start bit immediately following the stop bit is received (back-to-back frames).
REQ-025 Frame result SHALL be registered one clk cycle after the last stop sample.
REQ-026 Good frame: out = data byte and valid_out = 1 for one cycle, with error = 00 and valid_error = 0.
REQ-027 Any stop sample = 0: error[0] = 1.
REQ-028 Parity mismatch: error[1] = 1.
REQ-029 Any error: valid_error = 1 for one cycle; valid_out stays 0 and out holds the last good byte.
REQ-030 error SHALL hold its value until the next frame result.
REQ-031 Config register 4'h5, bits [1:0] = parity_cfg: bit0 enables parity, bit1 selects odd (1) or even (0); default 00.
REQ-032 Config register 4'h6, bit [0] = stop_two: 0 gives one stop bit, 1 gives two; default 0.
REQ-033 c_ready = 1 only while the FSM is in IDLE.
REQ-034 A write completes in the cycle where c_valid and c_ready are both 1; a write to any other address is accepted and ignored.
REQ-035 c_valid SHALL stay asserted until that cycle; the new config applies from the next frame.
REQ-036 The block SHALL NOT alter config while a frame is in progress.

Reset
REQ-037 rst SHALL force, on the clk edge: FSM to IDLE, counters to 0, out = 8'h00, valid_out = 0, error = 00, valid_error = 0, parity_cfg = 00, stop_two = 0.
REQ-038 rst SHALL preload the synchronizer flops to 1.
REQ-039 c_ready SHALL be 1 from the first cycle after reset.
REQ-040 rst asserted mid-frame SHALL discard the partial frame with no output pulse.

Structure
REQ-041 Package uart_pkg SHALL hold the state enum, OVERSAMPLE/DATA_BITS defaults, and register address constants ADDR_PARITY = 4'h5 and ADDR_STOP = 4'h6.
REQ-042 Sub-module uart_rx_sync SHALL be the 2-flop synchronizer; the rest of the design is one module.

Verification
REQ-043 Idle-high line, then frame for data 0xBA with a 1184-unit bit time, default config -> out = 0xBA, one valid_out pulse, error = 00.
REQ-044 Back-to-back frames 0x55, 0xAA, 0xFF, 0x80, 0x00 with no idle gap between stop and start -> five valid_out pulses with the matching bytes in order.
REQ-045 Low glitch of 5 clk cycles on idle line -> no valid_out, no valid_error, FSM back in IDLE.
REQ-046 Frame 0x3C with stop bit = 0 -> error = 01, valid_error pulse, no valid_out, out keeps previous value.
REQ-047 Write 4'h5 = 2'b01 (even parity), then send 0x07 with parity bit 0 -> error = 10; same byte with parity bit 1 -> out = 0x07, valid_out pulse.
REQ-048 c_valid with c_addr = 4'h6 issued mid-frame -> c_ready = 0 until IDLE, write completes then, and the next frame needs two stop bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, default frame geometry and
// config register addresses.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2
   } state_t;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   localparam logic [3:0] ADDR_PARITY = 4'h5;
   localparam logic [3:0] ADDR_STOP   = 4'h6;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line; 2 clk latency, no backpressure.
// Preloads to 1 (idle line) so reset never looks like a start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with optional parity and 1/2 stop bits; result 1 clk after last stop sample.
// Config writes stall (c_ready low) while a frame is in progress; received data has no backpressure.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in,
   input  logic                 clkinVGA,
   input  logic                 c_valid,
   input  logic [3:0]           c_addr,
   input  logic [7:0]           c_data,
   output logic                 c_ready,
   output logic [1:0]           error,
   output logic                 valid_error,
   output logic [DATA_BITS-1:0] out,
   output logic                 valid_out
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE/2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [DATA_BITS-1:0] data_q, data_nxt;
   logic                 stop_err, stop_err_nxt;
   logic                 par_err, par_err_nxt;
   logic                 frame_done;
   logic                 frame_stop_err;
   logic                 rx_s;
   logic [1:0]           parity_cfg;
   logic                 stop_two;
   logic                 cfg_wr;
   logic                 unused_ok;

   assign unused_ok = &{1'b0, clkinVGA, c_data[7:2]};

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (in),
      .q   (rx_s)
   );

   assign c_ready = (state == IDLE);
   assign cfg_wr  = c_valid && c_ready;

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt + 1'b1;
      idx_nxt        = idx;
      data_nxt       = data_q;
      stop_err_nxt   = stop_err;
      par_err_nxt    = par_err;
      frame_done     = 1'b0;
      frame_stop_err = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt      = '0;
            idx_nxt      = '0;
            stop_err_nxt = 1'b0;
            par_err_nxt  = 1'b0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // mid-bit recheck; every later sample lands a full bit period after this one
            if (cnt == CNT_MID) begin
               cnt_nxt   = '0;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt       = '0;
               data_nxt[idx] = rx_s;
               if (idx == IDX_LAST) begin
                  idx_nxt   = '0;
                  state_nxt = parity_cfg[0] ? PARITY : STOP1;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         PARITY: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt     = '0;
               par_err_nxt = (rx_s != ((^data_q) ^ parity_cfg[1]));
               state_nxt   = STOP1;
            end
         end
         STOP1: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (stop_two) begin
                  stop_err_nxt = !rx_s;
                  state_nxt    = STOP2;
               end else begin
                  frame_done     = 1'b1;
                  frame_stop_err = !rx_s;
                  state_nxt      = IDLE;
               end
            end
         end
         STOP2: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt        = '0;
               frame_done     = 1'b1;
               frame_stop_err = stop_err || !rx_s;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         data_q      <= '0;
         stop_err    <= 1'b0;
         par_err     <= 1'b0;
         out         <= '0;
         valid_out   <= 1'b0;
         error       <= 2'b00;
         valid_error <= 1'b0;
         parity_cfg  <= 2'b00;
         stop_two    <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         data_q      <= data_nxt;
         stop_err    <= stop_err_nxt;
         par_err     <= par_err_nxt;
         valid_out   <= frame_done && !frame_stop_err && !par_err;
         valid_error <= frame_done && (frame_stop_err || par_err);
         if (frame_done) begin
            error <= {par_err, frame_stop_err};
            if (!frame_stop_err && !par_err) out <= data_q;
         end
         if (cfg_wr) begin
            if (c_addr == ADDR_PARITY) parity_cfg <= c_data[1:0];
            if (c_addr == ADDR_STOP)   stop_two   <= c_data[0];
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven at 16x74-unit bit time, results
// collected by a negedge monitor and compared against hand-computed values.
module tb_uart_rx;

   localparam int CLK_HALF = 37;
   localparam int BT       = 1184;
   localparam int CLK_P    = 74;

   logic       clk = 1'b0;
   logic       rst;
   logic       in;
   logic       clkinVGA;
   logic       c_valid;
   logic [3:0] c_addr;
   logic [7:0] c_data;
   logic       c_ready;
   logic [1:0] error;
   logic       valid_error;
   logic [7:0] out;
   logic       valid_out;

   int checks = 0;
   int errors = 0;

   logic [7:0] got_q[$];
   logic [1:0] err_q[$];

   always #CLK_HALF clk = ~clk;

   uart_rx dut (
      .clk         (clk),
      .rst         (rst),
      .in          (in),
      .clkinVGA    (clkinVGA),
      .c_valid     (c_valid),
      .c_addr      (c_addr),
      .c_data      (c_data),
      .c_ready     (c_ready),
      .error       (error),
      .valid_error (valid_error),
      .out         (out),
      .valid_out   (valid_out)
   );

   always @(negedge clk) begin
      if (!rst) begin
         if (valid_out)   got_q.push_back(out);
         if (valid_error) err_q.push_back(error);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A zero stop bit is held low only past its sample point so the trailing
   // edge cannot be mistaken for the next start bit.
   task automatic drive_stop(input logic v);
      if (v) begin
         in = 1'b1;
         #(BT);
      end else begin
         in = 1'b0;
         #(10*CLK_P);
         in = 1'b1;
         #(BT - 10*CLK_P);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                             input int nstop, input logic s1, input logic s2);
      in = 1'b0;
      #(BT);
      for (int i = 0; i < 8; i++) begin
         in = d[i];
         #(BT);
      end
      if (par_en) begin
         in = par_bit;
         #(BT);
      end
      drive_stop(s1);
      if (nstop == 2) drive_stop(s2);
      in = 1'b1;
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
      int n;
      @(negedge clk);
      c_valid = 1'b1;
      c_addr  = a;
      c_data  = d;
      n = 0;
      while (!c_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!c_ready) check("cfg_write_timeout", 32'(c_ready), 32'd1);
      @(posedge clk);
      #1;
      c_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (30) @(negedge clk);
   endtask

   initial begin
      logic [7:0] seq [5];
      seq = '{8'h55, 8'hAA, 8'hFF, 8'h80, 8'h00};
      rst      = 1'b1;
      in       = 1'b1;
      clkinVGA = 1'b0;
      c_valid  = 1'b0;
      c_addr   = 4'h0;
      c_data   = 8'h00;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_c_ready", 32'(c_ready), 32'd1);
      check("rst_out", 32'(out), 32'h00);
      check("rst_error", 32'(error), 32'd0);
      check("rst_valid_out", 32'(valid_out), 32'd0);
      check("rst_valid_error", 32'(valid_error), 32'd0);
      repeat (10) @(negedge clk);

      // single frame, default config
      send_frame(8'hBA, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      settle();
      check("ba_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("ba_byte", 32'(got_q[0]), 32'hBA);
      check("ba_err_pulses", 32'(err_q.size()), 32'd0);
      check("ba_error", 32'(error), 32'd0);
      got_q.delete();
      err_q.delete();

      // back-to-back, no idle gap
      for (int i = 0; i < 5; i++) send_frame(seq[i], 1'b0, 1'b0, 1, 1'b1, 1'b1);
      settle();
      check("b2b_count", 32'(got_q.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < got_q.size()) check($sformatf("b2b_byte%0d", i), 32'(got_q[i]), 32'(seq[i]));
      check("b2b_err_pulses", 32'(err_q.size()), 32'd0);
      got_q.delete();
      err_q.delete();

      // 5-cycle low glitch
      @(negedge clk);
      in = 1'b0;
      #(5*CLK_P);
      in = 1'b1;
      settle();
      check("glitch_valid_out", 32'(got_q.size()), 32'd0);
      check("glitch_valid_err", 32'(err_q.size()), 32'd0);
      check("glitch_idle", 32'(c_ready), 32'd1);

      // framing error after a good byte
      send_frame(8'h5A, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      settle();
      got_q.delete();
      send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b1);
      settle();
      check("ferr_pulses", 32'(err_q.size()), 32'd1);
      if (err_q.size() > 0) check("ferr_code", 32'(err_q[0]), 32'b01);
      check("ferr_error_hold", 32'(error), 32'b01);
      check("ferr_valid_out", 32'(got_q.size()), 32'd0);
      check("ferr_out_kept", 32'(out), 32'h5A);
      err_q.delete();

      // even parity: 0x07 has three ones, so the correct parity bit is 1
      cfg_write(4'h5, 8'h01);
      send_frame(8'h07, 1'b1, 1'b0, 1, 1'b1, 1'b1);
      settle();
      check("perr_pulses", 32'(err_q.size()), 32'd1);
      if (err_q.size() > 0) check("perr_code", 32'(err_q[0]), 32'b10);
      check("perr_valid_out", 32'(got_q.size()), 32'd0);
      err_q.delete();
      send_frame(8'h07, 1'b1, 1'b1, 1, 1'b1, 1'b1);
      settle();
      check("pok_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("pok_byte", 32'(got_q[0]), 32'h07);
      check("pok_error", 32'(error), 32'd0);
      check("pok_err_pulses", 32'(err_q.size()), 32'd0);
      got_q.delete();

      // stop_two write issued mid-frame is held off until IDLE
      cfg_write(4'h5, 8'h00);
      @(negedge clk);
      fork
         send_frame(8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1);
         begin
            #(3*BT);
            check("mid_c_ready", 32'(c_ready), 32'd0);
            cfg_write(4'h6, 8'h01);
            check("mid_write_after_frame", 32'(got_q.size()), 32'd1);
         end
      join
      settle();
      if (got_q.size() > 0) check("mid_byte", 32'(got_q[0]), 32'h11);
      got_q.delete();
      send_frame(8'h4D, 1'b0, 1'b0, 2, 1'b1, 1'b0);
      settle();
      check("stop2_err_pulses", 32'(err_q.size()), 32'd1);
      if (err_q.size() > 0) check("stop2_err_code", 32'(err_q[0]), 32'b01);
      check("stop2_no_out", 32'(got_q.size()), 32'd0);
      err_q.delete();
      send_frame(8'h4D, 1'b0, 1'b0, 2, 1'b1, 1'b1);
      settle();
      check("stop2_ok_count", 32'(got_q.size()), 32'd1);
      check("stop2_ok_out", 32'(out), 32'h4D);
      got_q.delete();

      // reset mid-frame
      @(negedge clk);
      in = 1'b0;
      #(BT);
      in = 1'b1;
      #(BT);
      in = 1'b0;
      #(BT);
      @(negedge clk);
      rst = 1'b1;
      in  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rrst_c_ready", 32'(c_ready), 32'd1);
      check("rrst_out", 32'(out), 32'h00);
      check("rrst_error", 32'(error), 32'd0);
      repeat (400) @(negedge clk);
      check("rrst_no_out", 32'(got_q.size()), 32'd0);
      check("rrst_no_err", 32'(err_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #(2000*BT);
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule
